// File: rtl/cmp_seq_wide_if.sv
// rtl/cmp_seq_wide_if.sv - word-pair stream, cascade and result bundle for cmp_seq_wide
interface cmp_seq_wide_if #(
  parameter int WORD_W = 16
);
  logic              start;
  logic              fi_big;
  logic              fi_equal;
  logic              fi_small;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              fo_big;
  logic              fo_equal;
  logic              fo_small;

  // Source side: requests comparisons and streams word pairs
  modport master (
    output start, fi_big, fi_equal, fi_small, a_word, b_word, in_valid,
    input  in_ready, busy, done, fo_big, fo_equal, fo_small
  );

  // Comparator side
  modport slave (
    input  start, fi_big, fi_equal, fi_small, a_word, b_word, in_valid,
    output in_ready, busy, done, fo_big, fo_equal, fo_small
  );
endinterface

// File: rtl/cmp_seq_wide.sv
// rtl/cmp_seq_wide.sv - sequential wide-operand magnitude comparator, MS word first
module cmp_seq_wide #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  cmp_seq_wide_if.slave      bus
);
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {ACC_EQ, ACC_BIG, ACC_SMALL} acc_t;

  state_t            r_state;
  acc_t              r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_fo_big;
  logic              r_fo_equal;
  logic              r_fo_small;

  logic [WORD_W-1:0] w_a;
  logic [WORD_W-1:0] w_b;
  logic              w_beat;
  acc_t              w_acc_next;
  acc_t              w_acc_init;

  assign w_a    = bus.a_word;
  assign w_b    = bus.b_word;
  assign w_beat = (r_state == S_RUN) && bus.in_valid;

  // Once a more-significant word has decided the result, later words cannot change it
  always_comb begin
    w_acc_next = r_acc;
    if (r_acc == ACC_EQ) begin
      if (w_a > w_b)
        w_acc_next = ACC_BIG;
      else if (w_a < w_b)
        w_acc_next = ACC_SMALL;
    end
  end

  // Cascade-in priority big > small > equal; no flag set counts as equal
  always_comb begin
    w_acc_init = ACC_EQ;
    if (bus.fi_big)
      w_acc_init = ACC_BIG;
    else if (bus.fi_small)
      w_acc_init = ACC_SMALL;
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= ACC_EQ;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fo_big   <= 1'b0;
      r_fo_equal <= 1'b1;
      r_fo_small <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= w_acc_init;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_fo_big   <= (w_acc_next == ACC_BIG);
              r_fo_equal <= (w_acc_next == ACC_EQ);
              r_fo_small <= (w_acc_next == ACC_SMALL);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = (r_state == S_RUN);
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.fo_big   = r_fo_big;
  assign bus.fo_equal = r_fo_equal;
  assign bus.fo_small = r_fo_small;
endmodule

// File: tb/tb_cmp_seq_wide.sv
// tb/tb_cmp_seq_wide.sv - table-driven and corner-case bench for cmp_seq_wide
module tb_cmp_seq_wide;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  cmp_seq_wide_if #(.WORD_W(16)) bus ();

  cmp_seq_wide #(.WORD_W(16), .NUM_WORDS(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fi;   // {big, equal, small}
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  fo;   // expected {big, equal, small}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] fo_now();
    return {bus.fo_big, bus.fo_equal, bus.fo_small};
  endfunction

  // One comparison; optional idle gap before word gap_at, optional start pulses while running
  task automatic run_cmp(input logic [2:0] fi, input logic [63:0] a, input logic [63:0] b,
                         input int gap_at, input int gap_len, input bit poke_start,
                         output int done_cyc, output int done_cnt);
    int cyc;
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    cyc = 0;
    bus.start = 1'b1;
    {bus.fi_big, bus.fi_equal, bus.fi_small} = fi;
    bus.in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (w == gap_at) begin
        for (int s = 0; s < gap_len; s++) begin
          @(negedge clk);
          cyc++;
          if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
          bus.start    = 1'b0;
          bus.in_valid = 1'b0;
          bus.a_word   = 16'hDEAD;
          bus.b_word   = 16'h0000;
        end
      end
      @(negedge clk);
      cyc++;
      if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      bus.start    = poke_start && (w == 1 || w == 2);
      bus.a_word   = a[63 - 16*w -: 16];
      bus.b_word   = b[63 - 16*w -: 16];
      bus.in_valid = 1'b1;
    end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    int dc;
    int dn;
    errors = 0;
    checks = 0;

    vecs[0] = '{3'b010, 64'h1970_1970_1970_1970, 64'h1970_1970_1970_1970, 3'b010};
    vecs[1] = '{3'b010, 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 3'b100};
    vecs[2] = '{3'b010, 64'hABCD_ABCD_ABCD_1234, 64'hABCD_ABCD_ABCD_1235, 3'b001};
    vecs[3] = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 3'b001};
    vecs[4] = '{3'b100, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100};
    vecs[5] = '{3'b000, 64'h0005_0005_0005_0005, 64'h0005_0005_0005_0005, 3'b010};
    vecs[6] = '{3'b110, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 3'b100};
    vecs[7] = '{3'b011, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 3'b001};
    vecs[8] = '{3'b010, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100};
    vecs[9] = '{3'b010, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 3'b100};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.fi_big   = 1'b0;
    bus.fi_equal = 1'b1;
    bus.fi_small = 1'b0;
    bus.a_word   = '0;
    bus.b_word   = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_fo", 32'(fo_now()), 32'b010);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_cmp(vecs[i].fi, vecs[i].a, vecs[i].b, -1, 0, 1'b0, dc, dn);
      chk($sformatf("vec%0d_fo", i), 32'(fo_now()), 32'(vecs[i].fo));
      chk($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'd5);
      chk($sformatf("vec%0d_done_count", i), 32'(dn), 32'd1);
    end

    // Three idle cycles between beats delay done by three cycles
    run_cmp(3'b010, vecs[2].a, vecs[2].b, 2, 3, 1'b0, dc, dn);
    chk("stall_fo", 32'(fo_now()), 32'b001);
    chk("stall_done_cycle", 32'(dc), 32'd8);
    chk("stall_done_count", 32'(dn), 32'd1);

    // start pulses during RUN must not queue a second comparison
    run_cmp(3'b010, vecs[1].a, vecs[1].b, -1, 0, 1'b1, dc, dn);
    chk("restart_fo", 32'(fo_now()), 32'b100);
    chk("restart_done_cycle", 32'(dc), 32'd5);
    chk("restart_done_count", 32'(dn), 32'd1);

    // Reset after two beats discards the comparison
    @(negedge clk);
    bus.start = 1'b1;
    {bus.fi_big, bus.fi_equal, bus.fi_small} = 3'b010;
    @(negedge clk);
    bus.start = 1'b0;
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);
    bus.a_word = 16'h0000; bus.b_word = 16'h0001; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("run_fo_hold", 32'(fo_now()), 32'b100);
    bus.a_word = 16'h0000; bus.b_word = 16'h0001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_fo", 32'(fo_now()), 32'b010);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    bus.in_valid = 1'b0;
    chk("midrst_no_done", 32'(dn), 32'd0);

    run_cmp(3'b010, vecs[2].a, vecs[2].b, -1, 0, 1'b0, dc, dn);
    chk("after_rst_fo", 32'(fo_now()), 32'b001);
    chk("after_rst_done_cycle", 32'(dc), 32'd5);
    chk("after_rst_done_count", 32'(dn), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmp_seq_wide.md
Name: cmp_seq_wide

Overview:
- Sequential wide-operand magnitude comparator.
- Compares two NUM_WORDS×WORD_W operands streamed one word pair per beat, most-significant word first, over a valid/ready handshake.
- Produces the same one-hot big/equal/small result and fi_*/fo_* cascade semantics as the combinational 16-bit comparator.
- Replaces a long chain of combinational comparators with one datapath iterated over time; sits between a word-stream source and any consumer of fo_* results.

Parameters:
- WORD_W, 16, width of each operand word.
- NUM_WORDS, 4, words per operand (>=1); operand width = WORD_W*NUM_WORDS.

Ports:
- sys_clk  input  1  clock, all state on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a comparison; sampled only in IDLE.
- fi_big  input  1  cascade-in: more-significant section already has a>b; sampled with start.
- fi_equal  input  1  cascade-in: more-significant section equal; sampled with start.
- fi_small  input  1  cascade-in: more-significant section already has a<b; sampled with start.
- a_word  input  WORD_W  current word of operand a.
- b_word  input  WORD_W  current word of operand b.
- in_valid  input  1  a_word/b_word valid.
- in_ready  output  1  block accepts a word pair this cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse: fo_* updated with the new result.
- fo_big  output  1  result a>b.
- fo_equal  output  1  result a==b.
- fo_small  output  1  result a<b.

Behaviour:
- Reset, asynchronous and any time, including mid-RUN:
  - FSM to IDLE; word counter 0; accumulator = equal.
  - in_ready=0, busy=0, done=0, fo_big=0, fo_equal=1, fo_small=0.
  - A partially consumed comparison is discarded; no done is produced for it.
- FSM states: IDLE, RUN, DONE. All outputs are registered except in_ready, which is (state==RUN).
- IDLE:
  - On start=1, initialise the accumulator from fi_*, priority fi_big > fi_small > fi_equal; all-zero fi_* is treated as equal.
  - Clear the counter and go to RUN.
  - fo_* keep their previous values.
- RUN:
  - in_ready=1. A beat occurs when in_valid && in_ready.
  - On each beat, if the accumulator is equal, set it to big if a_word>b_word, small if a_word<b_word, else leave it equal. If the accumulator is already big or small, keep it; the word is still consumed.
  - Comparison is unsigned.
  - Counter increments per beat. The beat with counter==NUM_WORDS-1 moves the FSM to DONE and loads fo_* from the post-beat accumulator value.
  - Cycles with in_valid=0 stall; no state change.
- DONE:
  - done=1 for exactly this cycle; fo_* hold the new result, one-hot.
  - Next cycle returns to IDLE.
- start is ignored in RUN and DONE; no queuing.
- Latency: with in_valid held high, start at cycle 0 gives beats in cycles 1..NUM_WORDS and done in cycle NUM_WORDS+1.
- fo_* remain stable from a done pulse until the next done pulse or reset.
- Counter width is max(1,$clog2(NUM_WORDS)). NUM_WORDS=1 behaves as one beat then DONE.

Test Plan:
- After reset: fo_big/fo_equal/fo_small=0/1/0, in_ready=0, busy=0, done=0.
- fi=0/1/0, 4 words all a=b=16'h1970, in_valid held → done at cycle 5 after start; fo=0/1/0.
- fi=0/1/0, word0 a=16'h0001 b=16'h0000, words1-3 a=16'h0000 b=16'hFFFF → fo_big=1; first decision wins and all 4 words are consumed.
- fi=0/1/0, words0-2 equal 16'hABCD, word3 a=16'h1234 b=16'h1235 → fo_small=1. Repeat with in_valid low for 3 cycles between beats → same result; done delayed by 3 cycles.
- fi_small=1 (fi_equal=0), all words a=16'hFFFF b=16'h0000 → fo_small=1.
- Assert start again during RUN → ignored, exactly one done pulse. Deassert sys_rst_n after 2 beats → outputs at reset values, no done. A fresh start then completes normally.
